// File: rtl/rr_grant_sequencer_if.sv
// rtl/rr_grant_sequencer_if.sv - request/grant bundle between requesters and the round-robin sequencer
interface rr_grant_sequencer_if;
    logic [3:0] req;
    logic       done;
    logic [3:0] grant;
    logic [1:0] gnt_idx;
    logic       gnt_valid;
    logic       timeout;

    modport master (
        output req,
        output done,
        input  grant,
        input  gnt_idx,
        input  gnt_valid,
        input  timeout
    );

    modport slave (
        input  req,
        input  done,
        output grant,
        output gnt_idx,
        output gnt_valid,
        output timeout
    );
endinterface

// File: rtl/rr_grant_sequencer.sv
// rtl/rr_grant_sequencer.sv - 4-way round-robin arbiter with bounded tenure and decoded one-hot grant
module rr_grant_sequencer #(
    parameter int unsigned MAX_HOLD = 8,
    parameter int unsigned PTR_INIT = 0
) (
    input logic                 clk,
    input logic                 rst,
    rr_grant_sequencer_if.slave bus
);
    localparam int unsigned HW = $clog2(MAX_HOLD);
    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] GRANT = 1'b1;

    logic [0:0]    state;
    logic [1:0]    ptr;
    logic [HW-1:0] hold_cnt;
    logic [1:0]    winner;
    logic [1:0]    cand;
    logic          found;
    logic          held;
    logic          expired;
    logic          rel;

    // Scan from the priority pointer; the first requester found wins.
    always_comb begin
        winner = ptr;
        cand   = ptr;
        found  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cand = ptr + 2'(i);
            if (!found && bus.req[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
    end

    assign held    = bus.req[bus.gnt_idx];
    assign expired = (hold_cnt == HW'(MAX_HOLD - 1));
    assign rel     = bus.done || !held || expired;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            ptr           <= 2'(PTR_INIT);
            hold_cnt      <= '0;
            bus.gnt_idx   <= 2'd0;
            bus.gnt_valid <= 1'b0;
            bus.grant     <= 4'b0000;
            bus.timeout   <= 1'b0;
        end else begin
            bus.timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (|bus.req) begin
                        bus.gnt_idx   <= winner;
                        bus.gnt_valid <= 1'b1;
                        bus.grant     <= 4'b0001 << winner;
                        hold_cnt      <= '0;
                        state         <= GRANT;
                    end
                end
                GRANT: begin
                    if (rel) begin
                        bus.gnt_idx   <= 2'd0;
                        bus.gnt_valid <= 1'b0;
                        bus.grant     <= 4'b0000;
                        ptr           <= bus.gnt_idx + 2'd1;
                        hold_cnt      <= '0;
                        state         <= IDLE;
                        // Only a pure expiry counts as a timeout; done or withdrawal wins.
                        bus.timeout   <= expired && !bus.done && held;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
